// File: rtl/reverb_engine.sv
// reverb_engine: parallel feedback combs feeding series allpasses, all
// sharing one fixed-point multiplier; one input sample is processed per pass.
`ifndef FIXED_POINT
`define FIXED_POINT 10
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 1024
`endif

module reverb_engine #(
    parameter int DATA_W    = 32,
    parameter int FP        = `FIXED_POINT,
    parameter int N_COMB    = 4,
    parameter int N_ALLPASS = 2,
    parameter int MAXDELAY  = `MAX_FILTER_FIFO_LENGTH
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  sample_en,
    input  logic                                  enable,
    input  logic                                  write,
    input  logic [N_COMB+N_ALLPASS-1:0][31:0]     tau,
    input  logic [N_COMB+N_ALLPASS:0][DATA_W-1:0] gain,
    input  logic [DATA_W-1:0]                     in,
    output logic [DATA_W-1:0]                     out,
    output logic                                  out_valid,
    output logic                                  busy,
    output logic                                  overrun
);
    localparam int NF = N_COMB + N_ALLPASS;
    localparam int AW = (MAXDELAY > 1) ? $clog2(MAXDELAY) : 1;
    localparam int IW = (NF > 1) ? $clog2(NF) : 1;
    localparam logic [IW-1:0] LAST_COMB = IW'(N_COMB - 1);
    localparam logic [IW-1:0] LAST = IW'(NF - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MAXDELAY - 1);
    localparam logic signed [DATA_W-1:0] MAXV = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MINV = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {CLEAR, IDLE, COMB, ALLP, MIX} state_t;

    function automatic logic signed [DATA_W-1:0] sat_sum(
        input logic [DATA_W:0] s
    );
        if (s[DATA_W] != s[DATA_W-1])
            return s[DATA_W] ? MINV : MAXV;
        return s[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_p(
        input logic signed [2*DATA_W-1:0] p
    );
        logic signed [2*DATA_W-1:0] s;
        s = p >>> FP;
        if (s[2*DATA_W-1:DATA_W-1] == '0 || s[2*DATA_W-1:DATA_W-1] == '1)
            return s[DATA_W-1:0];
        return s[2*DATA_W-1] ? MINV : MAXV;
    endfunction

    function automatic logic [31:0] clamp_tau(input logic [31:0] t);
        if (t == 32'd0)
            return 32'd1;
        if (t > 32'(MAXDELAY))
            return 32'(MAXDELAY);
        return t;
    endfunction

    state_t state_q, state_d;
    logic [AW-1:0] clr_cnt, wp, rd_addr;
    logic [IW-1:0] idx;
    logic phase, pend;
    logic [NF-1:0][31:0] tau_sh;
    logic [NF:0][DATA_W-1:0] g_sh;
    logic signed [DATA_W-1:0] x_q, d_q, w_q, v_q, acc, acc_nx;
    logic signed [DATA_W-1:0] mul_a, mul_b, p_sat, d_rd, wdata;
    logic [2*DATA_W-1:0] ea, eb;
    logic signed [2*DATA_W-1:0] prod;
    logic [31:0] ra_sum;
    logic we;
    logic [DATA_W-1:0] mem [NF][MAXDELAY];

    // The single shared multiplier; operand mux below selects the user.
    assign ea = {{DATA_W{mul_a[DATA_W-1]}}, mul_a};
    assign eb = {{DATA_W{mul_b[DATA_W-1]}}, mul_b};
    assign prod = $signed(ea * eb);
    assign p_sat = sat_p(prod);

    assign ra_sum = 32'(wp) + 32'(MAXDELAY) - tau_sh[idx];
    assign rd_addr = AW'((ra_sum >= 32'(MAXDELAY)) ?
                         ra_sum - 32'(MAXDELAY) : ra_sum);
    assign d_rd = mem[idx][rd_addr];
    assign acc_nx = sat_sum({acc[DATA_W-1], acc} + {d_q[DATA_W-1], d_q});
    assign busy = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR: if (clr_cnt == LAST_ADDR) state_d = IDLE;
            IDLE:  if (sample_en && enable) state_d = COMB;
            COMB:  if (phase && idx == LAST_COMB)
                       state_d = (N_ALLPASS == 0) ? MIX : ALLP;
            ALLP:  if (phase && idx == LAST) state_d = MIX;
            MIX:   state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        we    = 1'b0;
        wdata = '0;
        unique case (state_q)
            COMB: begin
                mul_a = $signed(g_sh[idx]);
                mul_b = d_q;
                we    = phase;
                wdata = sat_sum({x_q[DATA_W-1], x_q} + {p_sat[DATA_W-1], p_sat});
            end
            ALLP: begin
                mul_a = $signed(g_sh[idx]);
                mul_b = phase ? w_q : d_rd;
                we    = phase;
                wdata = w_q;
            end
            MIX: begin
                mul_a = $signed(g_sh[NF]);
                mul_b = v_q;
            end
            default: ;
        endcase
    end

    // Delay lines carry no reset; CLEAR zeroes them after every reset.
    always_ff @(posedge clk) begin
        for (int f = 0; f < NF; f++) begin
            if (state_q == CLEAR)
                mem[f][clr_cnt] <= '0;
            else if (we && idx == IW'(f))
                mem[f][wp] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= CLEAR;
            clr_cnt   <= '0;
            idx       <= '0;
            phase     <= 1'b0;
            wp        <= '0;
            x_q       <= '0;
            d_q       <= '0;
            w_q       <= '0;
            v_q       <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            pend      <= 1'b0;
            tau_sh    <= {NF{32'd1}};
            g_sh      <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= 1'b0;
            if (sample_en && (state_q == COMB || state_q == ALLP ||
                              state_q == MIX))
                overrun <= 1'b1;
            else if (write)
                overrun <= 1'b0;
            if (write && state_q != IDLE)
                pend <= 1'b1;
            unique case (state_q)
                CLEAR: clr_cnt <= clr_cnt + 1'b1;
                IDLE: begin
                    if (write || pend) begin
                        for (int i = 0; i < NF; i++)
                            tau_sh[i] <= clamp_tau(tau[i]);
                        g_sh <= gain;
                        pend <= 1'b0;
                    end
                    if (sample_en && enable) begin
                        x_q   <= in;
                        acc   <= '0;
                        idx   <= '0;
                        phase <= 1'b0;
                    end else if (sample_en) begin
                        out       <= in;
                        out_valid <= 1'b1;
                    end
                end
                COMB: begin
                    phase <= ~phase;
                    if (!phase) begin
                        d_q <= d_rd;
                    end else begin
                        acc <= acc_nx;
                        idx <= (idx == LAST) ? '0 : idx + 1'b1;
                        if (idx == LAST_COMB)
                            v_q <= acc_nx;
                    end
                end
                ALLP: begin
                    phase <= ~phase;
                    if (!phase) begin
                        d_q <= d_rd;
                        w_q <= sat_sum({v_q[DATA_W-1], v_q} +
                                       {p_sat[DATA_W-1], p_sat});
                    end else begin
                        v_q <= sat_sum({d_q[DATA_W-1], d_q} -
                                       {p_sat[DATA_W-1], p_sat});
                        idx <= (idx == LAST) ? '0 : idx + 1'b1;
                    end
                end
                MIX: begin
                    out       <= p_sat;
                    out_valid <= 1'b1;
                    wp        <= (wp == LAST_ADDR) ? '0 : wp + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reverb_engine.sv
// Directed-vector bench for reverb_engine: a single-comb instance and a
// comb+allpass instance share clock, reset and sample strobes.
module tb_reverb_engine;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic sample_en = 1'b0;
    logic enable = 1'b1;
    logic write = 1'b0;
    logic [31:0] in = '0;
    logic [0:0][31:0] m_tau;
    logic [1:0][31:0] m_gain;
    logic [1:0][31:0] a_tau;
    logic [2:0][31:0] a_gain;
    logic [31:0] m_out, a_out;
    logic m_valid, m_busy, m_ovr;
    logic a_valid, a_busy, a_ovr;
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    reverb_engine #(
        .DATA_W(32), .FP(10), .N_COMB(1), .N_ALLPASS(0), .MAXDELAY(8)
    ) u_dut (
        .clk(clk), .rstn(rstn), .sample_en(sample_en), .enable(enable),
        .write(write), .tau(m_tau), .gain(m_gain), .in(in),
        .out(m_out), .out_valid(m_valid), .busy(m_busy), .overrun(m_ovr)
    );

    reverb_engine #(
        .DATA_W(32), .FP(10), .N_COMB(1), .N_ALLPASS(1), .MAXDELAY(8)
    ) u_ap (
        .clk(clk), .rstn(rstn), .sample_en(sample_en), .enable(enable),
        .write(write), .tau(a_tau), .gain(a_gain), .in(in),
        .out(a_out), .out_valid(a_valid), .busy(a_busy), .overrun(a_ovr)
    );

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (9) @(negedge clk);
    endtask

    task automatic cfg(input logic [31:0] t0, input logic [31:0] g0,
                       input logic [31:0] sc, input logic [31:0] t1,
                       input logic [31:0] g1);
        @(negedge clk);
        m_tau[0] = t0;  m_gain[0] = g0;  m_gain[1] = sc;
        a_tau[0] = t0;  a_gain[0] = g0;
        a_tau[1] = t1;  a_gain[1] = g1;  a_gain[2] = sc;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    // Strobe one sample and wait (bounded) for the chosen instance's output.
    task automatic send(input logic signed [31:0] v, input bit en,
                        input bit ap, output logic signed [31:0] res,
                        output int lat);
        res = '0;
        lat = 0;
        @(negedge clk);
        sample_en = 1'b1;
        enable = en;
        in = v;
        @(negedge clk);
        sample_en = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if ((ap ? a_valid : m_valid) === 1'b1) begin
                lat = i;
                res = ap ? a_out : m_out;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int busy_n;
        int vld_n;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        vecs++;
        if (m_out !== 32'd0) begin
            errs++; $display("FAIL reset_out: got %0h, expected 0", m_out);
        end
        vecs++;
        if (m_valid !== 1'b0) begin
            errs++; $display("FAIL reset_valid: got %b, expected 0", m_valid);
        end
        vecs++;
        if (m_ovr !== 1'b0) begin
            errs++; $display("FAIL reset_overrun: got %b, expected 0", m_ovr);
        end
        vecs++;
        if (m_busy !== 1'b1) begin
            errs++; $display("FAIL reset_busy: got %b, expected 1", m_busy);
        end
        rstn = 1'b1;
        busy_n = 0;
        vld_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_busy === 1'b1) busy_n++;
            if (m_valid === 1'b1) vld_n++;
            sample_en = (i == 2);
            @(negedge clk);
        end
        sample_en = 1'b0;
        vecs++;
        if (busy_n != 8) begin
            errs++; $display("FAIL clear_busy_cycles: got %0d, expected 8", busy_n);
        end
        vecs++;
        if (m_busy !== 1'b0) begin
            errs++; $display("FAIL clear_done: busy %b, expected 0", m_busy);
        end
        vecs++;
        if (m_ovr !== 1'b0 || vld_n != 0) begin
            errs++;
            $display("FAIL clear_ignore: overrun %b valids %0d, expected 0 0",
                     m_ovr, vld_n);
        end
    endtask

    task automatic test_comb_impulse();
        logic signed [31:0] res, exp;
        int lat;
        do_reset();
        cfg(3, 512, 1024, 1, 0);
        for (int s = 0; s <= 10; s++) begin
            send((s == 0) ? 1024 : 0, 1'b1, 1'b0, res, lat);
            exp = (s == 3) ? 1024 : (s == 6) ? 512 : (s == 9) ? 256 : 0;
            vecs++;
            if (lat == 0 || res !== exp) begin
                errs++;
                $display("FAIL comb_s%0d: got %0d (lat %0d), expected %0d",
                         s, res, lat, exp);
            end
        end
    endtask

    task automatic test_allpass();
        logic signed [31:0] res, exp;
        int lat;
        do_reset();
        cfg(1, 0, 1024, 2, 512);
        for (int s = 0; s <= 6; s++) begin
            send((s == 0) ? 1024 : 0, 1'b1, 1'b1, res, lat);
            exp = (s == 1) ? -512 : (s == 3) ? 768 : (s == 5) ? 384 : 0;
            vecs++;
            if (lat != 6 || res !== exp) begin
                errs++;
                $display("FAIL allpass_s%0d: got %0d (lat %0d), expected %0d lat 6",
                         s, res, lat, exp);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [31:0] res, exp;
        int lat;
        do_reset();
        cfg(1, 1024, 1024, 1, 0);
        for (int s = 0; s <= 4; s++) begin
            send(32'h7FFF_FFFF, 1'b1, 1'b0, res, lat);
            exp = (s == 0) ? 32'sd0 : 32'sh7FFF_FFFF;
            vecs++;
            if (lat == 0 || res !== exp) begin
                errs++;
                $display("FAIL sat_s%0d: got %0h (lat %0d), expected %0h",
                         s, res, lat, exp);
            end
        end
    endtask

    task automatic test_overrun();
        logic signed [31:0] res;
        int lat;
        int vld_n;
        do_reset();
        cfg(1, 0, 1024, 1, 0);
        @(negedge clk); sample_en = 1'b1; enable = 1'b1; in = 10;
        @(negedge clk); sample_en = 1'b0;
        @(negedge clk); sample_en = 1'b1; in = 99;
        @(negedge clk); sample_en = 1'b0;
        vld_n = 0;
        repeat (10) begin
            if (m_valid === 1'b1) vld_n++;
            @(negedge clk);
        end
        vecs++;
        if (vld_n != 1) begin
            errs++; $display("FAIL overrun_drop: %0d outputs, expected 1", vld_n);
        end
        vecs++;
        if (m_ovr !== 1'b1) begin
            errs++; $display("FAIL overrun_set: got %b, expected 1", m_ovr);
        end
        @(negedge clk); write = 1'b1;
        @(negedge clk); write = 1'b0;
        vecs++;
        if (m_ovr !== 1'b0) begin
            errs++; $display("FAIL overrun_clear: got %b, expected 0", m_ovr);
        end
        send(0, 1'b1, 1'b0, res, lat);
        vecs++;
        if (lat == 0 || res !== 32'sd10) begin
            errs++; $display("FAIL overrun_next: got %0d, expected 10", res);
        end
    endtask

    task automatic test_bypass_latency();
        logic signed [31:0] res;
        int lat;
        do_reset();
        cfg(1, 0, 1024, 1, 0);
        send(-300, 1'b0, 1'b0, res, lat);
        vecs++;
        if (lat != 1 || res !== -32'sd300) begin
            errs++;
            $display("FAIL bypass: got %0d lat %0d, expected -300 lat 1", res, lat);
        end
        send(5, 1'b1, 1'b0, res, lat);
        vecs++;
        if (lat != 4 || res !== 32'sd0) begin
            errs++;
            $display("FAIL latency_a: got %0d lat %0d, expected 0 lat 4", res, lat);
        end
        send(7, 1'b1, 1'b0, res, lat);
        vecs++;
        if (lat != 4 || res !== 32'sd5) begin
            errs++;
            $display("FAIL latency_b: got %0d lat %0d, expected 5 lat 4", res, lat);
        end
    endtask

    task automatic test_write_pending();
        logic signed [31:0] res;
        int lat;
        do_reset();
        cfg(1, 0, 1024, 1, 0);
        send(100, 1'b1, 1'b0, res, lat);
        @(negedge clk); sample_en = 1'b1; in = 300;
        @(negedge clk); sample_en = 1'b0;
        @(negedge clk);
        m_gain[1] = 512; a_gain[2] = 512; write = 1'b1;
        @(negedge clk); write = 1'b0;
        res = '0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            if (m_valid === 1'b1) begin
                lat = i; res = m_out; break;
            end
            @(negedge clk);
        end
        vecs++;
        if (lat == 0 || res !== 32'sd100) begin
            errs++; $display("FAIL write_midsample: got %0d, expected 100", res);
        end
        repeat (3) @(negedge clk);
        send(0, 1'b1, 1'b0, res, lat);
        vecs++;
        if (lat == 0 || res !== 32'sd150) begin
            errs++; $display("FAIL write_pending: got %0d, expected 150", res);
        end
    endtask

    task automatic test_reset_clamp();
        logic signed [31:0] res, exp;
        int lat;
        int busy_n;
        int vld_n;
        do_reset();
        cfg(1, 0, 1024, 1, 0);
        @(negedge clk); sample_en = 1'b1; enable = 1'b1; in = 55;
        @(negedge clk); sample_en = 1'b0; rstn = 1'b0;
        vld_n = 0;
        @(negedge clk);
        if (m_valid === 1'b1) vld_n++;
        rstn = 1'b1;
        busy_n = 0;
        for (int i = 0; i < 12; i++) begin
            if (m_busy === 1'b1) busy_n++;
            if (m_valid === 1'b1) vld_n++;
            @(negedge clk);
        end
        vecs++;
        if (vld_n != 0) begin
            errs++; $display("FAIL midreset_valid: got %0d, expected 0", vld_n);
        end
        vecs++;
        if (busy_n != 8) begin
            errs++; $display("FAIL midreset_busy: got %0d, expected 8", busy_n);
        end
        cfg(0, 0, 1024, 1, 0);
        for (int s = 0; s <= 2; s++) begin
            send((s == 0) ? 1024 : 0, 1'b1, 1'b0, res, lat);
            exp = (s == 1) ? 1024 : 0;
            vecs++;
            if (lat == 0 || res !== exp) begin
                errs++;
                $display("FAIL tau0_s%0d: got %0d, expected %0d", s, res, exp);
            end
        end
        do_reset();
        cfg(20, 0, 1024, 1, 0);
        for (int s = 0; s <= 9; s++) begin
            send((s == 0) ? 1024 : 0, 1'b1, 1'b0, res, lat);
            exp = (s == 8) ? 1024 : 0;
            vecs++;
            if (lat == 0 || res !== exp) begin
                errs++;
                $display("FAIL tau20_s%0d: got %0d, expected %0d", s, res, exp);
            end
        end
    endtask

    initial begin
        m_tau = '{32'd1};
        m_gain = '0;
        a_tau = '{32'd1, 32'd1};
        a_gain = '0;
        test_reset();
        test_comb_impulse();
        test_allpass();
        test_saturation();
        test_overrun();
        test_bypass_latency();
        test_write_pending();
        test_reset_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/reverb_engine.md
REVERB_ENGINE -- requirements
Module: reverb_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32: signed fixed-point sample and gain width.
REQ-002 SHALL have parameter FP, default `FIXED_POINT: number of fractional bits.
REQ-003 SHALL have parameter N_COMB, default 4, range 1..8: number of parallel feedback comb filters.
REQ-004 SHALL have parameter N_ALLPASS, default 2, range 0..4: number of series allpass filters.
REQ-005 SHALL have parameter MAXDELAY, default `MAX_FILTER_FIFO_LENGTH: per-filter delay-line depth in samples.
REQ-006 SHALL have port clk, input, 1 bit: sole clock.
REQ-007 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port sample_en, input, 1 bit: one-cycle strobe marking a new input sample.
REQ-009 SHALL have port enable, input, 1 bit: 1 = reverb, 0 = bypass.
REQ-010 SHALL have port write, input, 1 bit: request to load tau/gain.
REQ-011 SHALL have port tau, input, [N_COMB+N_ALLPASS] x 32 bits: delays in samples; combs first, then allpasses.
REQ-012 SHALL have port gain, input, [N_COMB+N_ALLPASS+1] x DATA_W bits: filter gains in the same order; the last entry is the output scale.
REQ-013 SHALL have port in, input, DATA_W bits: input sample, sampled on sample_en.
REQ-014 SHALL have port out, output, DATA_W bits: processed sample, held between updates.
REQ-015 SHALL have port out_valid, output, 1 bit: one-cycle pulse when out updates.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port overrun, output, 1 bit: sticky flag for a sample dropped while busy.

Function
REQ-018 SHALL use states CLEAR, IDLE, COMB, ALLP, MIX; exactly one multiplier, time-shared across all filters.
REQ-019 CLEAR SHALL write 0 to every address of every delay line, 1 address per cycle, MAXDELAY cycles, then go to IDLE.
REQ-020 IDLE with sample_en=1 and enable=1 SHALL latch in and go to COMB, filter index k=0.
REQ-021 COMB filter k SHALL take 2 cycles: cycle 1 reads d=buf_k[(wp-tau_k) mod MAXDELAY]; cycle 2 writes buf_k[wp]=sat(x+g_k*d) and adds d to acc.
REQ-022 After the last comb, the FSM SHALL enter ALLP with v=acc; if N_ALLPASS=0 it SHALL enter MIX directly.
REQ-023 ALLP filter j SHALL take 2 cycles: cycle 1 reads d and computes w=sat(v+g_j*d); cycle 2 writes buf_j[wp]=w and sets v=sat(d-g_j*w).
REQ-024 MIX SHALL set out=sat(g_scale*v), pulse out_valid, advance wp modulo MAXDELAY, and return to IDLE.
REQ-025 Latency from sample_en to out_valid SHALL be exactly 2*(N_COMB+N_ALLPASS)+2 cycles.
REQ-026 Every product SHALL be a 2*DATA_W-bit signed product, arithmetic-shifted right by FP, then saturated to the DATA_W signed range; acc SHALL also saturate.
REQ-027 Effective tau SHALL be clamped: 0 becomes 1; values above MAXDELAY become MAXDELAY.
REQ-028 IDLE with sample_en=1 and enable=0 SHALL set out=in on the next cycle, pulse out_valid, and leave the buffers and wp untouched.
REQ-029 A sample_en arriving while busy=1 SHALL be dropped and SHALL set overrun; overrun SHALL clear on write.
REQ-030 write in IDLE SHALL copy tau/gain into shadow registers on that cycle; write while busy SHALL be held pending and applied on the first IDLE cycle.
REQ-031 If write and sample_en coincide in IDLE, the new values SHALL be loaded first and used for that sample.
REQ-032 Shadow registers SHALL be the only tau/gain source during processing; input changes mid-sample SHALL have no effect.

Reset
REQ-033 While rstn=0: out=0, out_valid=0, overrun=0, wp=0, acc=0, shadow tau=1, shadow gain=0, pending write=0, and the state SHALL be CLEAR.
REQ-034 After reset deassertion, busy SHALL be 1 for exactly MAXDELAY cycles, with sample_en ignored and overrun not set.
REQ-035 Reset asserted mid-sample SHALL abort processing, skip out_valid, and restart CLEAR.

Verification
All scenarios use N_COMB=1, N_ALLPASS=0, MAXDELAY=8, FP=10, DATA_W=32 unless stated, with 1.0 = 1024.
REQ-036 Comb impulse: tau=3, g=512, scale=1024, in=1024 at sample 0 then 0 -> out samples 3/6/9 = 1024/512/256, all others 0.
REQ-037 Allpass (N_ALLPASS=1): comb tau=1, g=0; allpass tau=2, g=512; impulse 1024 -> out samples 1/3/5 = -512/768/384.
REQ-038 Saturation: comb g=1024, tau=1, in=0x7FFFFFFF every sample -> out saturates at 0x7FFFFFFF, no wrap.
REQ-039 Overrun: sample_en pulsed 2 cycles after a prior sample_en -> second sample dropped, overrun=1; write -> overrun=0.
REQ-040 Bypass/latency: enable=0, in=-300 -> out=-300 one cycle later; enable=1 -> out_valid exactly 4 cycles after sample_en.
REQ-041 Reset/clamp: rstn pulsed mid-COMB -> no out_valid, busy for 8 cycles; tau=0 and tau=20 behave as 1 and 8.
